// File: rtl/ysyx_22040759_mem_arbiter.sv
// Memory port arbiter: shares one req/gnt/rvalid memory port between
// instruction fetch and the load/store path, one transaction at a time.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ifu_req_i/addr_i      fetch request (level) and 4-byte aligned PC
//   ifu_valid_o/inst_o    one-cycle fetch completion pulse and instruction
//   lsu_ren_i/wen_i       load/store request (level), both high = store
//   lsu_func3_i           access size and signedness
//   lsu_addr_i/wdata_i    access address and LSB-justified store data
//   lsu_rdata_o           extended load result
//   lsu_done_o/err_o      completion pulse, error flags a misaligned access
//   mem_*_o / mem_*_i     registered request side, grant and response side
//   stall_o               freeze PC and writeback until the access completes

module ysyx_22040759_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int XLEN   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_i,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_valid_o,
    output logic [31:0]         ifu_inst_o,
    input  logic                lsu_ren_i,
    input  logic                lsu_wen_i,
    input  logic [2:0]          lsu_func3_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [XLEN-1:0]     lsu_wdata_i,
    output logic [XLEN-1:0]     lsu_rdata_o,
    output logic                lsu_done_o,
    output logic                lsu_err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    output logic [XLEN/8-1:0]   mem_wmask_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [XLEN-1:0]     mem_rdata_i,
    output logic                stall_o
);

    localparam int NB = XLEN / 8;

    typedef enum logic [2:0] {
        IDLE,
        IF_REQ,
        IF_WAIT,
        LS_REQ,
        LS_WAIT
    } state_e;

    state_e              state_q;
    logic                ifu_valid_q;
    logic [31:0]         ifu_inst_q;
    logic [XLEN-1:0]     lsu_rdata_q;
    logic                lsu_done_q;
    logic                lsu_err_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [XLEN-1:0]     mem_wdata_q;
    logic [NB-1:0]       mem_wmask_q;
    logic [2:0]          f3_q;
    logic [2:0]          off_q;
    logic                ld_q;
    logic                pc2_q;

    logic                lsu_any;
    logic                lsu_go;
    logic                ifu_go;
    logic                misalign;
    logic [7:0]          size_mask;
    logic [XLEN-1:0]     wdata_sh;
    logic [NB-1:0]       wmask_sh;
    logic [XLEN-1:0]     rdata_sh;
    logic [XLEN-1:0]     ld_fmt;
    logic [31:0]         inst_sel;
    logic                unused_addr;

    assign unused_addr = ^ifu_addr_i[1:0];

    assign lsu_any = lsu_ren_i | lsu_wen_i;
    // A requester still seeing its own completion pulse is not re-served.
    assign lsu_go  = lsu_any & ~lsu_done_q;
    assign ifu_go  = ifu_req_i & ~ifu_valid_q;

    always_comb begin
        misalign  = 1'b0;
        size_mask = 8'h00;
        unique case (lsu_func3_i[1:0])
            2'd0: begin
                misalign  = 1'b0;
                size_mask = 8'h01;
            end
            2'd1: begin
                misalign  = lsu_addr_i[0];
                size_mask = 8'h03;
            end
            2'd2: begin
                misalign  = |lsu_addr_i[1:0];
                size_mask = 8'h0F;
            end
            2'd3: begin
                misalign  = |lsu_addr_i[2:0];
                size_mask = 8'hFF;
            end
        endcase
        // func3=111 has no defined access; report it like a misalignment.
        if (lsu_func3_i == 3'b111) begin
            misalign = 1'b1;
        end
    end

    assign wdata_sh = lsu_wdata_i << {lsu_addr_i[2:0], 3'b000};
    assign wmask_sh = NB'(size_mask) << lsu_addr_i[2:0];
    assign rdata_sh = mem_rdata_i >> {off_q, 3'b000};
    assign inst_sel = pc2_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];

    always_comb begin
        ld_fmt = rdata_sh;
        unique case (f3_q)
            3'b000: ld_fmt = {{(XLEN-8){rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001: ld_fmt = {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
            3'b010: ld_fmt = {{(XLEN-32){rdata_sh[31]}}, rdata_sh[31:0]};
            3'b100: ld_fmt = {{(XLEN-8){1'b0}}, rdata_sh[7:0]};
            3'b101: ld_fmt = {{(XLEN-16){1'b0}}, rdata_sh[15:0]};
            3'b110: ld_fmt = {{(XLEN-32){1'b0}}, rdata_sh[31:0]};
            default: ld_fmt = rdata_sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ifu_valid_q <= 1'b0;
            ifu_inst_q  <= '0;
            lsu_rdata_q <= '0;
            lsu_done_q  <= 1'b0;
            lsu_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            ld_q        <= 1'b0;
            pc2_q       <= 1'b0;
        end else begin
            ifu_valid_q <= 1'b0;
            lsu_done_q  <= 1'b0;
            lsu_err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (lsu_go) begin
                        if (misalign) begin
                            lsu_done_q  <= 1'b1;
                            lsu_err_q   <= 1'b1;
                            lsu_rdata_q <= '0;
                        end else begin
                            state_q     <= LS_REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= lsu_wen_i;
                            mem_addr_q  <= {lsu_addr_i[ADDR_W-1:3], 3'b000};
                            mem_wdata_q <= lsu_wen_i ? wdata_sh : '0;
                            mem_wmask_q <= lsu_wen_i ? wmask_sh : '0;
                            f3_q        <= lsu_func3_i;
                            off_q       <= lsu_addr_i[2:0];
                            ld_q        <= ~lsu_wen_i;
                        end
                    end else if (ifu_go) begin
                        state_q     <= IF_REQ;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= {ifu_addr_i[ADDR_W-1:3], 3'b000};
                        mem_wdata_q <= '0;
                        mem_wmask_q <= '0;
                        pc2_q       <= ifu_addr_i[2];
                    end
                end
                IF_REQ, LS_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= (state_q == IF_REQ) ? IF_WAIT : LS_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (mem_rvalid_i) begin
                        ifu_inst_q  <= inst_sel;
                        ifu_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                LS_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (ld_q) begin
                            lsu_rdata_q <= ld_fmt;
                        end
                        lsu_done_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ifu_valid_o = ifu_valid_q;
    assign ifu_inst_o  = ifu_inst_q;
    assign lsu_rdata_o = lsu_rdata_q;
    assign lsu_done_o  = lsu_done_q;
    assign lsu_err_o   = lsu_err_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;

    assign stall_o = (state_q != IDLE)
                   | ((ifu_req_i | lsu_any) & ~ifu_valid_q & ~lsu_done_q);

endmodule

// File: doc/ysyx_22040759_mem_arbiter.md
Name: ysyx_22040759_mem_arbiter

Overview:
- Sequences and shares the core's single memory port between instruction fetch (IFU) and the load/store path driven by the decoder's mem_ren/mem_wen/func3 controls.
- Issues one transaction at a time over a req/gnt/rvalid handshake.
- Formats load data (shift plus sign/zero extension per func3) and store byte masks.
- Drives a stall that freezes PC and register writeback until the access completes.

Parameters:
- ADDR_W, 64, address width of IFU, LSU and memory ports.
- XLEN, 64, data width; memory beat is XLEN bits, XLEN/8 byte lanes.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ifu_req  in  1  fetch request, level, held until ifu_valid
- ifu_addr  in  ADDR_W  fetch PC, 4-byte aligned
- ifu_valid  out  1  one-cycle pulse: ifu_inst valid
- ifu_inst  out  32  fetched instruction
- lsu_ren  in  1  load request, level (decoder mem_ren)
- lsu_wen  in  1  store request, level (decoder mem_wen)
- lsu_func3  in  3  access size/sign (000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu)
- lsu_addr  in  ADDR_W  ALU result
- lsu_wdata  in  XLEN  rs2 data, LSB-justified
- lsu_rdata  out  XLEN  extended load result
- lsu_done  out  1  one-cycle completion pulse
- lsu_err  out  1  valid with lsu_done: misaligned access, no memory transaction issued
- mem_req  out  1  request valid
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  beat-aligned address ({addr[ADDR_W-1:3],3'b0})
- mem_wdata  out  XLEN  store data shifted to lane
- mem_wmask  out  XLEN/8  byte enables
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  response (read data or write ack)
- mem_rdata  in  XLEN  read beat
- stall  out  1  freeze PC/writeback

Behaviour:
- States:
  - IDLE.
  - IF_REQ, IF_WAIT.
  - LS_REQ, LS_WAIT.
- Reset (async, rst_n=0): state IDLE; ifu_valid, lsu_done, lsu_err, mem_req, mem_we, mem_wmask at 0; ifu_inst, lsu_rdata, mem_addr, mem_wdata at 0.
- Arbitration in IDLE:
  - LSU (lsu_ren|lsu_wen) has priority over ifu_req.
  - lsu_ren and lsu_wen both high is treated as a store.
  - A requester whose completion pulse is high this cycle is ignored.
- Misalignment check: addr[0] for h, addr[1:0] for w, addr[2:0] for d. On misalignment, IDLE goes straight back to IDLE and the next cycle pulses lsu_done=1, lsu_err=1, lsu_rdata=0.
- mem_* outputs are registered, loaded on entry to *_REQ and held stable until mem_gnt.
- mem_req=1 only in *_REQ.
- On mem_gnt, *_REQ moves to *_WAIT and mem_req drops in the next cycle.
- Zero-wait case: gnt sampled in the first REQ cycle gives one REQ cycle.
- Store data/mask:
  - mem_wdata = lsu_wdata << (8*addr[2:0]).
  - mem_wmask = size mask (01, 03, 0F, FF) << addr[2:0].
  - Loads and fetch use mem_wmask = 0 and mem_we = 0.
- Fetch selects mem_rdata[63:32] when ifu_addr[2]=1, else [31:0].
- Load: (mem_rdata >> 8*addr[2:0]), truncated to size, sign-extended for func3[2]=0 and zero-extended otherwise. Unsupported func3=111 is treated as misaligned (lsu_err).
- On mem_rvalid in *_WAIT: capture data, return to IDLE, and pulse ifu_valid or lsu_done in the following cycle. mem_rvalid outside WAIT is ignored.
- Latency: minimum 3 cycles from request to pulse (REQ+gnt, WAIT+rvalid same next cycle, pulse).
- stall = (state != IDLE) | ((ifu_req | lsu_ren | lsu_wen) & ~ifu_valid & ~lsu_done). stall is combinational.
- The requester must drop its request in the cycle its pulse is high.
- Request withdrawal in REQ/WAIT is not allowed; the transaction still completes.
- Reset mid-transaction aborts with no pulse; the memory side must tolerate an abandoned request.

Test Plan:
- Fetch, ifu_addr=0x80000004, gnt in first cycle, rvalid next cycle with rdata=0x00000013_FFFFFFFF → ifu_inst=0x00000013, ifu_valid one cycle, 3 cycles total, stall high until the pulse.
- ld at addr 0x80000010, gnt delayed 3 cycles → mem_req/mem_addr stable 4 cycles; lsu_rdata=mem_rdata; mem_we=0.
- lb at addr 0x80000003, rdata byte3=0x80 → lsu_rdata=0xFFFFFFFFFFFFFF80. lbu same → 0x80.
- sh at addr 0x80000006, wdata=0x1234 → mem_wmask=0xC0, mem_wdata=0x1234<<48, mem_we=1; lsu_done after rvalid ack.
- lw at addr 0x80000002 → no mem_req, lsu_done=lsu_err=1 one cycle after request.
- ifu_req and lsu_ren asserted together in IDLE → LSU served first, fetch follows. rst_n low during LS_WAIT → outputs clear immediately, no lsu_done.
